dec16_rr_scheduler: RTL and testbench

Grant scheduler for the 16-way one-hot select resource built on `decoder4to16`. It arbitrates 16 request lines and drives the decoder's 4-bit index and enable, so at most one line is selected at a time. Each grant is held for a programmable number of cycles or until early release, and lines are served round-robin. The block sits between requesting agents and the shared one-hot select fabric.

---
 rtl/dec16_sched_pkg.sv | 39 +++
 rtl/decoder4to16.sv | 18 +
 rtl/dec16_rr_scheduler.sv | 109 ++++++++++
 tb/tb_dec16_rr_scheduler.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/dec16_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dec16_sched_pkg
//  Purpose  : Shared types, sizes and the wrapping first-set search for the
//             16-line grant scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package dec16_sched_pkg;

   localparam int N_LINES = 16;
   localparam int IDX_W   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Index of the first set bit at or above start, wrapping 15 -> 0.
   // Returns start when no bit is set; callers only use it with req nonzero.
   function automatic logic [IDX_W-1:0] first_from(
      input logic [N_LINES-1:0] req,
      input logic [IDX_W-1:0]   start
   );
      logic [IDX_W-1:0] k;
      logic             found;
      first_from = start;
      found      = 1'b0;
      for (int i = 0; i < N_LINES; i++) begin
         k = start + IDX_W'(i);
         if (!found && req[k]) begin
            first_from = k;
            found      = 1'b1;
         end
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/decoder4to16.sv
`default_nettype none
// ============================================================================
//  Module   : decoder4to16
//  Purpose  : 4-to-16 one-hot decoder with enable; all zeros when disabled.
//  Revision : 1.0  initial release
// ============================================================================
module decoder4to16 (
   input  logic [3:0]  in,
   input  logic        en,
   output logic [15:0] out
);

   for (genvar g = 0; g < 16; g++) begin : g_line
      assign out[g] = en && (in == 4'(g));
   end

endmodule
`default_nettype wire

// File: rtl/dec16_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : dec16_rr_scheduler
//  Purpose  : Holds one of 16 request lines granted for a programmable number
//             of cycles, with early release and a dead cycle between grants.
//  Config   : DEC16_ROUND_ROBIN_EN -> round-robin search from a rotating
//             pointer; undefined -> fixed priority, lowest index wins.
//  Revision : 1.0  initial release
// ============================================================================
module dec16_rr_scheduler
   import dec16_sched_pkg::*;
#(
   parameter int HOLD_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_LINES-1:0]  req,
   input  logic [HOLD_W-1:0]   hold_len,
   input  logic                early_release,
   output logic [N_LINES-1:0]  grant,
   output logic [IDX_W-1:0]    grant_idx,
   output logic                grant_vld,
   output logic                grant_done
);

   localparam logic [HOLD_W-1:0] C_HOLD_ONE = HOLD_W'(1);

   state_t             state_q,     state_d;
   logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
   logic [HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;
   logic [IDX_W-1:0]   winner;
   logic               grant_end;

`ifdef DEC16_ROUND_ROBIN_EN
   logic [IDX_W-1:0]   ptr_q, ptr_d;

   assign winner = first_from(req, ptr_q);
`else
   assign winner = first_from(req, '0);
`endif

   // All end conditions collapse into one termination event.
   assign grant_end = (hold_cnt_q == C_HOLD_ONE) || early_release || !req[grant_idx_q];

   always_comb begin
      state_d     = state_q;
      grant_idx_d = grant_idx_q;
      hold_cnt_d  = hold_cnt_q;
`ifdef DEC16_ROUND_ROBIN_EN
      ptr_d       = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d     = GRANT;
               grant_idx_d = winner;
               hold_cnt_d  = (hold_len == '0) ? C_HOLD_ONE : hold_len;
            end
         end
         GRANT: begin
            if (grant_end) begin
               state_d    = GAP;
               hold_cnt_d = '0;
`ifdef DEC16_ROUND_ROBIN_EN
               ptr_d      = grant_idx_q + IDX_W'(1);
`endif
            end else begin
               hold_cnt_d = hold_cnt_q - C_HOLD_ONE;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_idx_q <= '0;
         hold_cnt_q  <= '0;
`ifdef DEC16_ROUND_ROBIN_EN
         ptr_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         grant_idx_q <= grant_idx_d;
         hold_cnt_q  <= hold_cnt_d;
`ifdef DEC16_ROUND_ROBIN_EN
         ptr_q       <= ptr_d;
`endif
      end
   end

   assign grant_idx  = grant_idx_q;
   assign grant_vld  = (state_q == GRANT);
   assign grant_done = (state_q == GAP);

   decoder4to16 u_decoder (
      .in  (grant_idx_q),
      .en  (grant_vld),
      .out (grant)
   );

endmodule
`default_nettype wire

// File: tb/tb_dec16_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dec16_rr_scheduler
//  Purpose  : Directed self-checking bench for dec16_rr_scheduler.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dec16_rr_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] req;
   logic [3:0]  hold_len;
   logic        early_release;
   logic [15:0] grant;
   logic [3:0]  grant_idx;
   logic        grant_vld;
   logic        grant_done;

   int n_tests = 0;
   int n_fail  = 0;

   dec16_rr_scheduler #(.HOLD_W(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .hold_len      (hold_len),
      .early_release (early_release),
      .grant         (grant),
      .grant_idx     (grant_idx),
      .grant_vld     (grant_vld),
      .grant_done    (grant_done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compares {grant, grant_idx, grant_vld, grant_done} as one vector.
   task automatic chk(input string tag, input logic [15:0] e_grant, input logic [3:0] e_idx,
                      input logic e_vld, input logic e_done);
      logic [21:0] obs;
      logic [21:0] exp;
      obs = {grant, grant_idx, grant_vld, grant_done};
      exp = {e_grant, e_idx, e_vld, e_done};
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed grant=%h idx=%0d vld=%b done=%b, expected grant=%h idx=%0d vld=%b done=%b",
                tag, grant, grant_idx, grant_vld, grant_done, e_grant, e_idx, e_vld, e_done);
      end
   endtask

   logic [3:0] rr_order [4];

   initial begin
`ifdef DEC16_ROUND_ROBIN_EN
      rr_order = '{4'd0, 4'd1, 4'd15, 4'd0};
`else
      rr_order = '{4'd0, 4'd0, 4'd0, 4'd0};
`endif
      rst = 1'b1; req = '0; hold_len = '0; early_release = 1'b0;
      tick();
      tick();
      chk("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // No requests: stay idle
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_no_req", 16'h0000, 4'd0, 1'b0, 1'b0);
      end

      // Line 0 held high, hold 3: grant 3 cycles, gap, idle, repeat every 5
      req = 16'h0001; hold_len = 4'd3;
      for (int k = 0; k < 10; k++) begin
         tick();
         case (k % 5)
            0, 1, 2: chk("hold3_grant", 16'h0001, 4'd0, 1'b1, 1'b0);
            3:       chk("hold3_gap",   16'h0000, 4'd0, 1'b0, 1'b1);
            default: chk("hold3_idle",  16'h0000, 4'd0, 1'b0, 1'b0);
         endcase
      end
      req = '0;

      // Round-robin wrap 0,1,15,0 (fixed priority: 0 every time), from ptr 0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 16'h8003; hold_len = 4'd1;
      for (int g = 0; g < 4; g++) begin
         tick();
         chk("rr_grant", 16'(1) << rr_order[g], rr_order[g], 1'b1, 1'b0);
         tick();
         chk("rr_gap", 16'h0000, rr_order[g], 1'b0, 1'b1);
         tick();
         chk("rr_idle", 16'h0000, rr_order[g], 1'b0, 1'b0);
      end
      req = '0;
      tick();
      chk("rr_stop", 16'h0000, rr_order[3], 1'b0, 1'b0);

      // Early release on the 2nd cycle of a hold-8 grant
      hold_len = 4'd8; req = 16'h0010;
      tick();
      chk("rel_cyc1", 16'h0010, 4'd4, 1'b1, 1'b0);
      tick();
      chk("rel_cyc2", 16'h0010, 4'd4, 1'b1, 1'b0);
      early_release = 1'b1;
      tick();
      chk("rel_gap", 16'h0000, 4'd4, 1'b0, 1'b1);
      early_release = 1'b0; req = '0;
      tick();
      chk("rel_idle", 16'h0000, 4'd4, 1'b0, 1'b0);

      // Request drop ends the grant early
      hold_len = 4'd4; req = 16'h0020;
      tick();
      chk("drop_grant", 16'h0020, 4'd5, 1'b1, 1'b0);
      req = '0;
      tick();
      chk("drop_gap", 16'h0000, 4'd5, 1'b0, 1'b1);
      tick();
      chk("drop_idle", 16'h0000, 4'd5, 1'b0, 1'b0);

      // hold_len 0 behaves as 1
      hold_len = 4'd0; req = 16'h0400;
      tick();
      chk("hold0_grant", 16'h0400, 4'd10, 1'b1, 1'b0);
      tick();
      chk("hold0_gap", 16'h0000, 4'd10, 1'b0, 1'b1);
      req = '0;
      tick();
      chk("hold0_idle", 16'h0000, 4'd10, 1'b0, 1'b0);

      // Move the pointer to 4, then reset in the middle of a 4-cycle grant
      hold_len = 4'd1; req = 16'h0008;
      tick();
      chk("pre_grant", 16'h0008, 4'd3, 1'b1, 1'b0);
      tick();
      tick();
      hold_len = 4'd4;
      tick();
      chk("mid_cyc1", 16'h0008, 4'd3, 1'b1, 1'b0);
      tick();
      chk("mid_cyc2", 16'h0008, 4'd3, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      chk("mid_reset", 16'h0000, 4'd0, 1'b0, 1'b0);
      rst = 1'b0; req = 16'h0404;
      tick();
      chk("post_reset_grant", 16'h0004, 4'd2, 1'b1, 1'b0);
      req = '0;
      tick();
      chk("post_reset_gap", 16'h0000, 4'd2, 1'b0, 1'b1);
      tick();
      chk("post_reset_idle", 16'h0000, 4'd2, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
